// File: rtl/amo_sequencer.sv
// amo_sequencer: RV32A atomic sequencer and data-memory port arbiter.
// Owns the single data-memory port. In IDLE the normal load/store path passes
// straight through. For an atomic it sequences LR.W, SC.W and AMO*.W
// read-modify-write transactions, keeps a word-granular reservation, and holds
// the pipeline via stall until the one-cycle done pulse.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/_amo_op/_addr/_wdata  atomic request (funct5, rs1, rs2)
//   lsu_read_en/_write_en/_addr/_wdata  normal load/store request
//   mem_rdata                    synchronous read data (one cycle after read)
//   mem_read_enable/_write_enable/_address/_wdata  memory port
//   stall, done, rd_value, illegal  pipeline hold, completion, rd, bad request
//
// Build option: define AMO_MINMAX_EN to support AMOMIN/MAX/MINU/MAXU; when it
// is undefined those codes are treated as illegal and no compare logic exists.
module amo_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [4:0]        req_amo_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              lsu_read_en,
  input  logic              lsu_write_en,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rd_value,
  output logic              illegal
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
`ifdef AMO_MINMAX_EN
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_MODIFY, S_WRITE, S_SC_CHECK, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                resv_valid_q, resv_valid_d;
  logic [WORD_W-1:0]   resv_addr_q, resv_addr_d;
  logic [DATA_W-1:0]   old_q, old_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic                illegal_q, illegal_d;

  logic                op_legal;
  logic                resv_hit;
  logic [DATA_W-1:0]   amo_result;

  // Decode which funct5 codes this build accepts
  always_comb begin
    op_legal = 1'b0;
    case (req_amo_op)
      OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR: op_legal = 1'b1;
`ifdef AMO_MINMAX_EN
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  assign resv_hit = resv_valid_q && (resv_addr_q == req_addr[ADDR_W-1:2]);

  // Read-modify-write datapath; operates on the read data arriving in MODIFY
  always_comb begin
    amo_result = req_wdata;
    case (req_amo_op)
      OP_ADD:  amo_result = mem_rdata + req_wdata;
      OP_XOR:  amo_result = mem_rdata ^ req_wdata;
      OP_AND:  amo_result = mem_rdata & req_wdata;
      OP_OR:   amo_result = mem_rdata | req_wdata;
`ifdef AMO_MINMAX_EN
      OP_MIN:  amo_result = ($signed(mem_rdata) < $signed(req_wdata)) ? mem_rdata : req_wdata;
      OP_MAX:  amo_result = ($signed(mem_rdata) > $signed(req_wdata)) ? mem_rdata : req_wdata;
      OP_MINU: amo_result = (mem_rdata < req_wdata) ? mem_rdata : req_wdata;
      OP_MAXU: amo_result = (mem_rdata > req_wdata) ? mem_rdata : req_wdata;
`endif
      default: amo_result = req_wdata;
    endcase
  end

  // Next-state, port mux and outputs
  always_comb begin
    state_d          = state_q;
    resv_valid_d     = resv_valid_q;
    resv_addr_d      = resv_addr_q;
    old_d            = old_q;
    result_d         = result_q;
    rd_d             = rd_q;
    illegal_d        = illegal_q;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_wdata        = '0;
    stall            = 1'b0;
    done             = 1'b0;
    rd_value         = '0;
    illegal          = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_read_enable  = lsu_read_en;
        mem_write_enable = lsu_write_en;
        mem_address      = lsu_addr;
        mem_wdata        = lsu_wdata;
        // A plain store to the reserved word breaks the reservation
        if (lsu_write_en && resv_valid_q && (lsu_addr[ADDR_W-1:2] == resv_addr_q)) begin
          resv_valid_d = 1'b0;
        end
        if (req_valid) begin
          stall = 1'b1;
          if (op_legal && (req_addr[1:0] == 2'b00)) begin
            illegal_d = 1'b0;
            state_d   = (req_amo_op == OP_SC) ? S_SC_CHECK : S_READ;
          end else begin
            illegal_d = 1'b1;
            rd_d      = '0;
            state_d   = S_DONE;
          end
        end
      end
      S_READ: begin
        stall           = 1'b1;
        mem_read_enable = 1'b1;
        mem_address     = req_addr;
        state_d         = S_MODIFY;
      end
      S_MODIFY: begin
        stall = 1'b1;
        old_d = mem_rdata;
        rd_d  = mem_rdata;
        if (req_amo_op == OP_LR) begin
          resv_valid_d = 1'b1;
          resv_addr_d  = req_addr[ADDR_W-1:2];
          state_d      = S_DONE;
        end else begin
          result_d = amo_result;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        stall            = 1'b1;
        mem_write_enable = 1'b1;
        mem_address      = req_addr;
        mem_wdata        = result_q;
        if (resv_hit) begin
          resv_valid_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_SC_CHECK: begin
        stall = 1'b1;
        if (resv_hit) begin
          mem_write_enable = 1'b1;
          mem_address      = req_addr;
          mem_wdata        = req_wdata;
          rd_d             = '0;
        end else begin
          rd_d = DATA_W'(1'b1);
        end
        resv_valid_d = 1'b0;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        rd_value = rd_q;
        illegal  = illegal_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset silences every output, so a write in flight is dropped
    if (!reset_n) begin
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_address      = '0;
      mem_wdata        = '0;
      stall            = 1'b0;
      done             = 1'b0;
      rd_value         = '0;
      illegal          = 1'b0;
    end
  end

  // State and reservation registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
      old_q        <= '0;
      result_q     <= '0;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
      old_q        <= old_d;
      result_q     <= result_d;
      rd_q         <= rd_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Randomized self-checking bench for amo_sequencer against a word-level
// reference model of memory contents, reservation and per-op latency.
module tb_amo_sequencer;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [4:0]  req_amo_op;
  logic [31:0] req_addr, req_wdata;
  logic        lsu_read_en, lsu_write_en;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read_enable, mem_write_enable;
  logic [31:0] mem_address, mem_wdata;
  logic        stall, done, illegal;
  logic [31:0] rd_value;

  always #5 clk = ~clk;

  amo_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_amo_op(req_amo_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .lsu_read_en(lsu_read_en), .lsu_write_en(lsu_write_en), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .mem_rdata(mem_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .stall(stall), .done(done), .rd_value(rd_value), .illegal(illegal)
  );

  // Synchronous word memory attached to the port
  logic [31:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_write_enable) tb_mem[mem_address[9:2]] <= mem_wdata;
    if (mem_read_enable)  mem_rdata <= tb_mem[mem_address[9:2]];
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  bit          ref_rv;
  logic [29:0] ref_ra;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit op_ok(input logic [4:0] op);
    case (op)
      OP_LR, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR: return 1'b1;
`ifdef AMO_MINMAX_EN
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] amo_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_MIN:  return (sa < sb) ? a : b;
      OP_MAX:  return (sa > sb) ? a : b;
      OP_MINU: return (a < b) ? a : b;
      OP_MAXU: return (a > b) ? a : b;
      default: return b;
    endcase
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
    tb_mem[addr[9:2]]  = val;
    ref_mem[addr[9:2]] = val;
  endtask

  // Issue one atomic request (entered at posedge+1 in IDLE) and check it
  task automatic run_req(input string tag, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic [31:0] exp_rd, old;
    int          exp_lat, lat;
    bit          exp_ill, got, any_en, stall_bad;
    logic [7:0]  idx;
    idx     = addr[9:2];
    exp_ill = 1'b0;
    if (!op_ok(op) || addr[1:0] != 2'b00) begin
      exp_ill = 1'b1; exp_rd = 32'd0; exp_lat = 1;
    end else if (op == OP_LR) begin
      exp_rd = ref_mem[idx]; ref_rv = 1'b1; ref_ra = addr[31:2]; exp_lat = 3;
    end else if (op == OP_SC) begin
      if (ref_rv && ref_ra == addr[31:2]) begin
        ref_mem[idx] = wd; exp_rd = 32'd0;
      end else begin
        exp_rd = 32'd1;
      end
      ref_rv = 1'b0; exp_lat = 2;
    end else begin
      old = ref_mem[idx];
      exp_rd = old;
      ref_mem[idx] = amo_calc(op, old, wd);
      if (ref_rv && ref_ra == addr[31:2]) ref_rv = 1'b0;
      exp_lat = 4;
    end

    req_valid = 1'b1; req_amo_op = op; req_addr = addr; req_wdata = wd;
    lat = 0; got = 1'b0; any_en = 1'b0; stall_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (stall !== 1'b1) stall_bad = 1'b1;
      if (mem_read_enable || mem_write_enable) any_en = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":done"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, ":lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ":rd"}, rd_value, exp_rd);
      check({tag, ":illegal"}, 32'(illegal), 32'(exp_ill));
      check({tag, ":stall_at_done"}, 32'(stall), 32'd0);
      if (exp_ill) begin
        if (mem_read_enable || mem_write_enable) any_en = 1'b1;
        check({tag, ":no_mem_en"}, 32'(any_en), 32'd0);
      end
    end
    check({tag, ":stall_hold"}, 32'(stall_bad), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, ":mem"}, tb_mem[idx], ref_mem[idx]);
  endtask

  task automatic lsu_store(input logic [31:0] addr, input logic [31:0] val);
    lsu_write_en = 1'b1; lsu_addr = addr; lsu_wdata = val;
    @(posedge clk); #1;
    lsu_write_en = 1'b0;
    ref_mem[addr[9:2]] = val;
    if (ref_rv && ref_ra == addr[31:2]) ref_rv = 1'b0;
  endtask

  task automatic lsu_load(input string tag, input logic [31:0] addr);
    lsu_read_en = 1'b1; lsu_addr = addr;
    @(posedge clk); #1;
    lsu_read_en = 1'b0;
    check(tag, mem_rdata, ref_mem[addr[9:2]]);
  endtask

  logic [4:0] op_tab [13];

  initial begin
    bit          bad;
    logic [31:0] a, d;
    int          r;
    op_tab = '{OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
               OP_MIN, OP_MAX, OP_MINU, OP_MAXU, 5'b00101, 5'b11111};
    reset_n = 1'b0; req_valid = 1'b0; req_amo_op = '0; req_addr = '0; req_wdata = '0;
    lsu_read_en = 1'b1; lsu_write_en = 1'b0; lsu_addr = 32'h40; lsu_wdata = '0;
    ref_rv = 1'b0; ref_ra = '0;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), 32'(i) * 32'h01010101);

    // Reset: outputs forced low even with an LSU read pending
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_re", 32'(mem_read_enable), 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; lsu_read_en = 1'b0;

    // Directed cases
    set_word(32'h100, 32'd5);
    run_req("amoadd", OP_ADD, 32'h100, 32'd3);
    check("amoadd_mem8", tb_mem[8'h40], 32'd8);
    set_word(32'h200, 32'hAA);
    run_req("lr1", OP_LR, 32'h200, 32'd0);
    run_req("sc1", OP_SC, 32'h200, 32'h55);
    run_req("sc2", OP_SC, 32'h200, 32'h66);
    check("sc_mem55", tb_mem[8'h80], 32'h55);
    run_req("lr2", OP_LR, 32'h200, 32'd0);
    lsu_store(32'h202, 32'h1234);
    run_req("sc_broken", OP_SC, 32'h200, 32'h77);
    check("sc_lsu_val", tb_mem[8'h80], 32'h1234);
    set_word(32'h180, 32'hFFFFFFFF);
    run_req("amomax", OP_MAX, 32'h180, 32'd1);
    set_word(32'h180, 32'hFFFFFFFF);
    run_req("amomaxu", OP_MAXU, 32'h180, 32'd1);
    run_req("swap_mis", OP_SWAP, 32'h101, 32'h9);
    run_req("bad_op", 5'b00101, 32'h100, 32'h9);
    lsu_load("lsu_load", 32'h100);

    // Reset during MODIFY of an AMOADD
    run_req("lr_pre", OP_LR, 32'h300, 32'd0);
    req_valid = 1'b1; req_amo_op = OP_ADD; req_addr = 32'h100; req_wdata = 32'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_we", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; req_valid = 1'b0;
    ref_rv = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || stall || mem_write_enable) bad = 1'b1;
    end
    check("midrst_quiet", 32'(bad), 32'd0);
    check("midrst_mem", tb_mem[8'h40], ref_mem[8'h40]);
    @(posedge clk); #1;
    run_req("sc_after_rst", OP_SC, 32'h300, 32'h1);
    run_req("lr_after_rst", OP_LR, 32'h100, 32'd0);
    run_req("sc_ok_after_rst", OP_SC, 32'h100, 32'hBEEF);

    // Random mix over eight words
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 7)) * 32'd4;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) - 32'd4 : $urandom;
      if (r < 2) begin
        lsu_store(a + 32'($urandom_range(0, 3)), d);
      end else if (r == 2) begin
        lsu_load("rnd_load", a);
      end else begin
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        run_req("rnd", op_tab[$urandom_range(0, 12)], a, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
